// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional feature macro used by this slice: FETCH_TIMEOUT_EN (ack timeout + sticky error).
package fetch_pkg;

  localparam int          ADDR_W_DEF      = 16;
  localparam int          DATA_W_DEF      = 16;
  localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
  localparam int          TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory read port and decode handshake.
//
// Handshake rules:
//  - imem: the fetch unit holds imem_req=1 with a stable imem_addr until the memory
//    answers with imem_ack=1; imem_rdata is only meaningful in that ack cycle. The
//    request may be abandoned (reset or redirect), so the memory must not rely on it
//    completing.
//  - decode: instr/instr_pc are held stable while instr_valid=1; a transfer happens
//    on the rising edge where instr_valid=1 and instr_ready=1. instr_valid never
//    depends combinationally on instr_ready.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait counter for outstanding instruction fetches, with a sticky error flag.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,     // a new fetch transaction starts next cycle
  input  logic inc,     // a fetch cycle passed without ack
  output logic expire,  // this no-ack cycle is the TIMEOUT_CYC-th one
  output logic err
);

  localparam logic [3:0] LAST = 4'(TIMEOUT_CYC - 1);

  logic [3:0] cnt;

  assign expire = inc && (cnt == LAST);

  // Count consecutive unanswered fetch cycles; restart with every new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Error stays set until reset so a dead memory is visible to software.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (expire) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands one
// instruction at a time to decode. Execute can redirect the PC at any time.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that is not acked
// within TIMEOUT_CYC cycles and park the unit with a sticky fetch_err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  fetch_unit_if.master      bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state, next_state;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;
  logic              ack_take;
  logic              handshake;
  logic              to_expire;
  logic              to_inc;
  logic              to_clr;

  // An ack only counts in FETCH and only if no redirect supersedes it.
  assign ack_take  = (state == FETCH) && bus.imem_ack && !redirect;
  assign handshake = (state == HOLD) && bus.instr_ready;
  assign to_inc    = (state == FETCH) && !bus.imem_ack && !redirect;
  assign to_clr    = (next_state == FETCH) && ((state != FETCH) || redirect);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (reset),
    .clr    (to_clr),
    .inc    (to_inc),
    .expire (to_expire),
    .err    (fetch_err)
  );
`else
  logic unused_timeout;
  assign unused_timeout = to_inc ^ to_clr ^ (TIMEOUT_CYC == 0);
  assign to_expire      = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; redirect overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en && !fetch_err) next_state = FETCH;
      FETCH: begin
        if (bus.imem_ack)   next_state = HOLD;
        else if (to_expire) next_state = IDLE;
      end
      HOLD:    if (bus.instr_ready) next_state = en ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
    if (redirect) begin
      next_state = (en && !fetch_err) ? FETCH : IDLE;
    end
  end

  // PC: redirect target wins, otherwise advance (with wrap) on each accepted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (ack_take) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // Instruction register towards decode, captured with the address it came from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (ack_take) begin
      instr_q    <= bus.imem_rdata;
      instr_pc_q <= pc;
    end
  end

  // Valid flag: set on capture, dropped on handshake or when a redirect flushes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
    end else if (redirect) begin
      instr_valid_q <= 1'b0;
    end else if (ack_take) begin
      instr_valid_q <= 1'b1;
    end else if (handshake) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign state_dbg       = state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the 16-bit processor. Holds the PC and issues request/acknowledge reads to instruction memory.
- Captures each returned 16-bit instruction and presents it to the decode stage with a valid/ready handshake.
- Its PC-increment path and the branch target supplied by execute are what the downstream 16-bit 2:1 next-PC select chooses between. This block owns the registered side of that loop and accepts the resolved redirect.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width
- DATA_W, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYC, 15, max cycles waiting for imem_ack; used only with FETCH_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  fetch enable; 0 parks the unit in IDLE after the current transaction
- imem_req  out  1  read request to instruction memory
- imem_addr  out  ADDR_W  read address (equals pc while imem_req=1)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
- instr  out  DATA_W  registered instruction to decode
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts instr
- redirect  in  1  load new PC (branch/jump taken)
- redirect_pc  in  ADDR_W  target PC, sampled when redirect=1
- pc  out  ADDR_W  current fetch PC
- fetch_err  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, fetch_err=0.
- The FSM has three states: IDLE, FETCH, HOLD. imem_req=1 iff state==FETCH. imem_addr=pc, combinational.
- IDLE: if en=1, go to FETCH next cycle.
- FETCH: on imem_ack=1:
  - instr<=imem_rdata, instr_pc<=pc, instr_valid<=1
  - pc<=pc+1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000)
  - go to HOLD
  - Minimum latency: request cycle to instr_valid is 1 cycle after ack.
- HOLD: instr_valid=1, and instr/instr_pc stay stable until instr_ready=1. On the handshake, instr_valid<=0 and the FSM goes to FETCH if en=1, else IDLE. There is no back-to-back overlap, so throughput is at most one instruction per 2 cycles.
- en falling during FETCH: the transaction completes normally; the en check is made only at HOLD exit and in IDLE.
- redirect=1 takes priority over everything except reset, in any state:
  - pc<=redirect_pc, instr_valid<=0; next state is FETCH if en=1, else IDLE.
  - A coincident imem_ack is discarded: no capture, no increment.
  - A coincident instr_ready handshake completes but is superseded; decode sees no new valid.
- imem_ack outside FETCH is ignored.
- Reset asserted mid-transaction aborts immediately. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - If it reaches TIMEOUT_CYC: fetch_err<=1 (sticky until reset), state<=IDLE, and the unit stays in IDLE regardless of en until reset.
  - redirect still loads pc but does not leave IDLE while fetch_err=1.
- Undefined: no counter is built, fetch_err is tied 0, and FETCH waits indefinitely.

Decomposition:
- Package fetch_pkg contains:
  - state encoding constants: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2
  - default ADDR_W/DATA_W
  - RESET_PC default
- One natural sub-module, fetch_timeout_ctr: the counter and sticky error, instantiated only under FETCH_TIMEOUT_EN.
- The PC increment stays inline.

Test Plan:
- Reset, en=1, memory acks 1 cycle after req with rdata=16'hA5A5; instr_ready=1:
  - imem_addr sequence 0,1,2 …
  - instr=16'hA5A5 with instr_pc=0, then 1
  - pc increments once per fetch
- Hold instr_ready=0 for 5 cycles after valid: instr/instr_pc stable, no imem_req, pc=1; releasing ready gives req at addr 1 on the next cycle.
- pc=16'hFFFF fetch acked: instr_pc=16'hFFFF, pc=16'h0000, next imem_addr=0.
- redirect=1, redirect_pc=16'h0040 in the same cycle as imem_ack: no instr_valid, next imem_addr=16'h0040, following instr_pc=16'h0040.
- en=0 mid-FETCH: current fetch completes; after the handshake the FSM is in IDLE with imem_req=0; en=1 resumes at the incremented pc.
- With FETCH_TIMEOUT_EN and no ack for 15 cycles: fetch_err=1, imem_req=0, stays there despite en=1; reset clears it. Without the macro, fetch_err stays 0 and req stays high.
